mips_multicycle_control: RTL and testbench
==========================================

Name: mips_multicycle_control

Overview:
- Main control FSM of the multicycle MIPS datapath.
- Decodes the IR opcode and steps each instruction through fetch/decode/execute/memory/writeback.
- Drives every datapath select and enable, including alu_src_b, which selects the ALU B operand: 00 = B register, 01 = constant 4, 10 = sign-extended immediate, 11 = shifted sign-extended immediate (branch offset).
- Stalls on a memory ready handshake.

Parameters:
- STATE_W, 4, width of the state register and of the state debug port.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  synchronous active-low reset
- opcode  input  6  IR[31:26]; stable from the cycle after FETCH completes
- mem_ready  input  1  memory completes the current access this cycle
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load qualified by ALU zero (beq)
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  IR load
- mem_to_reg  output  1  register write data: 0 = ALUOut, 1 = MDR
- reg_dst  output  1  destination register: 0 = rt, 1 = rd
- reg_write  output  1  register file write enable
- alu_src_a  output  1  ALU A operand: 0 = PC, 1 = A register
- alu_src_b  output  2  ALU B operand select (encoding in Overview)
- alu_op  output  2  00 = add, 01 = sub, 10 = use funct field
- pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = exception vector
- instr_done  output  1  one-cycle pulse in the final state of each instruction
- exc  output  1  illegal-opcode pulse (optional feature)
- state  output  STATE_W  current state (debug)

Behaviour:
- Moore FSM. State register updates on the rising clk edge.
- All outputs are a combinational decode of the state, plus mem_ready in the memory states.
- Reset:
  - reset_n = 0 at a clk edge sets state to FETCH (0).
  - While reset_n = 0, every output is forced to 0; this includes alu_src_b = 00 and state = 0.
  - Reset asserted mid-instruction aborts it. No writes occur in the reset cycle.
- State encoding: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, ADDI_EXEC 10, ADDI_WB 11, EXCEPT 12. Codes 13–15 go to FETCH.
- Outputs per state (unlisted outputs = 0):
  - FETCH: mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00; ir_write = pc_write = mem_ready. Holds until mem_ready, so PC advances by 4 exactly once.
  - DECODE: alu_src_a = 0, alu_src_b = 11, alu_op = 00 (branch target to ALUOut).
  - MEM_ADDR and ADDI_EXEC: alu_src_a = 1, alu_src_b = 10, alu_op = 00.
  - MEM_READ: mem_read = 1, i_or_d = 1. Holds until mem_ready.
  - MEM_WRITE: mem_write = 1, i_or_d = 1, instr_done = mem_ready. Holds until mem_ready.
  - MEM_WB: reg_write = 1, mem_to_reg = 1, reg_dst = 0, instr_done = 1.
  - R_EXEC: alu_src_a = 1, alu_src_b = 00, alu_op = 10.
  - R_WB: reg_write = 1, reg_dst = 1, instr_done = 1.
  - BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond = 1, pc_source = 01, instr_done = 1.
  - JUMP: pc_write = 1, pc_source = 10, instr_done = 1.
  - ADDI_WB: reg_write = 1, reg_dst = 0, instr_done = 1.
- Transitions:
  - FETCH→DECODE on mem_ready.
  - DECODE on opcode:
    - 100011 (lw) or 101011 (sw) → MEM_ADDR
    - 000000 → R_EXEC
    - 000100 → BRANCH
    - 000010 → JUMP
    - 001000 → ADDI_EXEC
    - other → illegal (see Optional Feature)
  - MEM_ADDR→MEM_READ (lw) or MEM_WRITE (sw); opcode is re-read here.
  - MEM_READ→MEM_WB on mem_ready.
  - MEM_WRITE→FETCH on mem_ready.
  - R_EXEC→R_WB; ADDI_EXEC→ADDI_WB.
  - MEM_WB, R_WB, BRANCH, JUMP, ADDI_WB → FETCH.
- Latencies with mem_ready always 1:
  - lw 5 cycles; sw, R-type, addi 4; beq, j 3.
  - Each cycle mem_ready is low in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- mem_ready is ignored outside those three states.

Optional Feature:
- Macro: ILLEGAL_OP_TRAP_EN.
- Defined:
  - Illegal opcode in DECODE → EXCEPT.
  - EXCEPT drives pc_write = 1, pc_source = 11, exc = 1, instr_done = 1 for one cycle, then → FETCH.
- Undefined:
  - Illegal opcode in DECODE → FETCH (executes as a nop, instr_done = 1 in DECODE).
  - EXCEPT is unreachable; exc is tied 0.

Test Plan:
- Reset: hold reset_n = 0 for 2 cycles, then release → during reset all outputs 0; first cycle after release state = 0, mem_read = 1, alu_src_b = 01.
- R-type: opcode = 000000, mem_ready = 1 → states 0,1,6,7,0. In state 6 alu_src_b = 00, alu_op = 10. In state 7 reg_write = 1, reg_dst = 1, instr_done = 1.
- lw with stall: opcode = 100011, mem_ready low for 3 cycles in MEM_READ → 8 total cycles. alu_src_b = 10 in MEM_ADDR. reg_write = 1, mem_to_reg = 1 only in MEM_WB.
- Fetch stall: mem_ready = 0 for 2 cycles in FETCH → pc_write and ir_write stay 0 until the mem_ready = 1 cycle, then pulse exactly once.
- beq and j: opcode 000100 → BRANCH with alu_src_b = 00, alu_op = 01, pc_write_cond = 1, pc_source = 01. opcode 000010 → JUMP with pc_write = 1, pc_source = 10. Each takes 3 cycles.
- Illegal opcode 111111, and reset_n = 0 asserted in MEM_READ:
  - with ILLEGAL_OP_TRAP_EN, exc = 1 and pc_source = 11 for one cycle;
  - without it, DECODE → FETCH with exc = 0;
  - the mid-instruction reset returns the FSM to FETCH with no reg_write.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/memory/writeback.
// Optional feature: define ILLEGAL_OP_TRAP_EN to trap illegal opcodes through the EXCEPT state.
module mips_multicycle_control #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic               instr_done,
  output logic               exc,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH     = STATE_W'(0),
    S_DECODE    = STATE_W'(1),
    S_MEM_ADDR  = STATE_W'(2),
    S_MEM_READ  = STATE_W'(3),
    S_MEM_WB    = STATE_W'(4),
    S_MEM_WRITE = STATE_W'(5),
    S_R_EXEC    = STATE_W'(6),
    S_R_WB      = STATE_W'(7),
    S_BRANCH    = STATE_W'(8),
    S_JUMP      = STATE_W'(9),
    S_ADDI_EXEC = STATE_W'(10),
    S_ADDI_WB   = STATE_W'(11),
    S_EXCEPT    = STATE_W'(12)
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t state_reg, state_next;

  always_ff @(posedge clk) begin
    if (!reset_n) state_reg <= S_FETCH;
    else          state_reg <= state_next;
  end

  assign state = reset_n ? state_reg : '0;

  always_comb begin
    state_next    = S_FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    exc           = 1'b0;

    case (state_reg)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = 2'b01;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        state_next = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEM_ADDR;
          OP_RTYPE:     state_next = S_R_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          OP_ADDI:      state_next = S_ADDI_EXEC;
          default: begin
`ifdef ILLEGAL_OP_TRAP_EN
            state_next = S_EXCEPT;
`else
            instr_done = 1'b1;
            state_next = S_FETCH;
`endif
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        state_next = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_read   = 1'b1;
        i_or_d     = 1'b1;
        state_next = mem_ready ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WRITE: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
        state_next = mem_ready ? S_FETCH : S_MEM_WRITE;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b10;
        state_next = S_R_WB;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
      end
      S_ADDI_EXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        state_next = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
`ifdef ILLEGAL_OP_TRAP_EN
      S_EXCEPT: begin
        pc_write   = 1'b1;
        pc_source  = 2'b11;
        exc        = 1'b1;
        instr_done = 1'b1;
      end
`endif
      default: state_next = S_FETCH;
    endcase

    // Reset masks every control line so nothing is written in the reset cycle.
    if (!reset_n) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      instr_done    = 1'b0;
      exc           = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: walks each instruction class cycle by cycle
// and checks state plus the full control word against hand-written constants.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, exc;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  mips_multicycle_control #(.STATE_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .instr_done(instr_done), .exc(exc), .state(state)
  );

  always #5 clk = ~clk;

  // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
  //  reg_dst, reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_source[1:0], instr_done, exc}
  logic [17:0] ctrl;
  assign ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                 reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done, exc};

  localparam logic [17:0] C_ZERO     = 18'b0;
  localparam logic [17:0] C_FETCH_R  = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] C_FETCH_W  = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] C_DECODE   = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [17:0] C_DEC_ILL  = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_1_0;
  localparam logic [17:0] C_ADDR     = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] C_MREAD    = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] C_MWRITE_W = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] C_MWRITE_R = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
  localparam logic [17:0] C_MEM_WB   = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_1_0;
  localparam logic [17:0] C_R_EXEC   = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [17:0] C_R_WB     = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0;
  localparam logic [17:0] C_BRANCH   = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_1_0;
  localparam logic [17:0] C_JUMP     = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_1_0;
  localparam logic [17:0] C_ADDI_WB  = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_1_0;
  localparam logic [17:0] C_EXCEPT   = 18'b1_0_0_0_0_0_0_0_0_0_00_00_11_1_1;

  // Check the current cycle away from the edge, then advance one clock.
  task automatic cyc(input string tag, input logic [3:0] exp_state, input logic [17:0] exp_ctrl);
    #2;
    checks++;
    assert (state === exp_state) else begin
      errors++;
      $error("FAIL %s state: got %0d expected %0d", tag, state, exp_state);
    end
    checks++;
    assert (ctrl === exp_ctrl) else begin
      errors++;
      $error("FAIL %s ctrl: got %b expected %b", tag, ctrl, exp_ctrl);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    opcode    = 6'b000000;
    mem_ready = 1'b1;

    cyc("rst0", 4'd0, C_ZERO);
    cyc("rst1", 4'd0, C_ZERO);
    reset_n = 1'b1;
    $display("reset released");

    // R-type, no stalls: 0,1,6,7
    opcode = 6'b000000;
    cyc("r_fetch", 4'd0, C_FETCH_R);
    cyc("r_decode", 4'd1, C_DECODE);
    cyc("r_exec", 4'd6, C_R_EXEC);
    cyc("r_wb", 4'd7, C_R_WB);
    $display("rtype done");

    // lw with three wait cycles in MEM_READ: 8 cycles total
    opcode = 6'b100011;
    cyc("lw_fetch", 4'd0, C_FETCH_R);
    cyc("lw_decode", 4'd1, C_DECODE);
    cyc("lw_addr", 4'd2, C_ADDR);
    mem_ready = 1'b0;
    cyc("lw_rd_wait0", 4'd3, C_MREAD);
    cyc("lw_rd_wait1", 4'd3, C_MREAD);
    cyc("lw_rd_wait2", 4'd3, C_MREAD);
    mem_ready = 1'b1;
    cyc("lw_rd", 4'd3, C_MREAD);
    cyc("lw_wb", 4'd4, C_MEM_WB);
    $display("lw done");

    // Fetch stall then sw with one write wait cycle
    opcode = 6'b101011;
    mem_ready = 1'b0;
    cyc("sw_fetch_wait0", 4'd0, C_FETCH_W);
    cyc("sw_fetch_wait1", 4'd0, C_FETCH_W);
    mem_ready = 1'b1;
    cyc("sw_fetch", 4'd0, C_FETCH_R);
    cyc("sw_decode", 4'd1, C_DECODE);
    cyc("sw_addr", 4'd2, C_ADDR);
    mem_ready = 1'b0;
    cyc("sw_wr_wait", 4'd5, C_MWRITE_W);
    mem_ready = 1'b1;
    cyc("sw_wr", 4'd5, C_MWRITE_R);
    $display("sw done");

    // beq, with mem_ready low in DECODE and BRANCH where it must be ignored
    opcode = 6'b000100;
    cyc("beq_fetch", 4'd0, C_FETCH_R);
    mem_ready = 1'b0;
    cyc("beq_decode", 4'd1, C_DECODE);
    cyc("beq_branch", 4'd8, C_BRANCH);
    mem_ready = 1'b1;
    $display("beq done");

    opcode = 6'b000010;
    cyc("j_fetch", 4'd0, C_FETCH_R);
    cyc("j_decode", 4'd1, C_DECODE);
    cyc("j_jump", 4'd9, C_JUMP);
    $display("j done");

    opcode = 6'b001000;
    cyc("addi_fetch", 4'd0, C_FETCH_R);
    cyc("addi_decode", 4'd1, C_DECODE);
    cyc("addi_exec", 4'd10, C_ADDR);
    cyc("addi_wb", 4'd11, C_ADDI_WB);
    $display("addi done");

    // Illegal opcode
    opcode = 6'b111111;
    cyc("ill_fetch", 4'd0, C_FETCH_R);
`ifdef ILLEGAL_OP_TRAP_EN
    cyc("ill_decode", 4'd1, C_DECODE);
    cyc("ill_except", 4'd12, C_EXCEPT);
`else
    cyc("ill_decode", 4'd1, C_DEC_ILL);
`endif
    cyc("ill_refetch", 4'd0, C_FETCH_R);
    $display("illegal opcode done");

    // Reset in MEM_READ aborts the lw with no register write
    opcode = 6'b100011;
    cyc("ab_decode", 4'd1, C_DECODE);
    cyc("ab_addr", 4'd2, C_ADDR);
    mem_ready = 1'b0;
    cyc("ab_rd_wait", 4'd3, C_MREAD);
    reset_n = 1'b0;
    mem_ready = 1'b1;
    cyc("ab_reset", 4'd0, C_ZERO);
    reset_n = 1'b1;
    cyc("ab_fetch", 4'd0, C_FETCH_R);
    $display("abort done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
